// File: rtl/apb_gpio_v2.sv
// APB GPIO controller: direction/output registers with atomic set/clear/toggle aliases,
// per-pin debounced inputs, four interrupt modes and a sticky write-1-to-clear status.
module apb_gpio_v2 #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_GPIO       = 32,
  parameter int DB_CNT_W       = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_GPIO-1:0]       gpio_in,
  output logic [NUM_GPIO-1:0]       gpio_out,
  output logic [NUM_GPIO-1:0]       gpio_dir,
  output logic                      interrupt
);

  localparam logic [3:0] ADDR_DIR     = 4'd0;
  localparam logic [3:0] ADDR_IN      = 4'd1;
  localparam logic [3:0] ADDR_OUT     = 4'd2;
  localparam logic [3:0] ADDR_OUTSET  = 4'd3;
  localparam logic [3:0] ADDR_OUTCLR  = 4'd4;
  localparam logic [3:0] ADDR_OUTTGL  = 4'd5;
  localparam logic [3:0] ADDR_INTEN   = 4'd6;
  localparam logic [3:0] ADDR_INTTYP0 = 4'd7;
  localparam logic [3:0] ADDR_INTTYP1 = 4'd8;
  localparam logic [3:0] ADDR_STATUS  = 4'd9;
  localparam logic [3:0] ADDR_DBEN    = 4'd10;
  localparam logic [3:0] ADDR_DBPRESC = 4'd11;

  logic [NUM_GPIO-1:0] dir_q, dir_d, out_q, out_d, inten_q, inten_d;
  logic [NUM_GPIO-1:0] type0_q, type0_d, type1_q, type1_d, status_q, status_d;
  logic [NUM_GPIO-1:0] dben_q, dben_d;
  logic [NUM_GPIO-1:0] sync0_q, sync1_q, rIn_q, rIn_d, rPrev_q, sample_q, sample_d;
  logic [DB_CNT_W-1:0] presc_q, presc_d, cnt_q, cnt_d;

  logic [3:0]          regIdx;
  logic                access, mapped, wrEn, tick;
  logic [NUM_GPIO-1:0] wd, wr1c, upd, rise, fall, modeEv, ev;
  logic                unusedBus;

  assign regIdx    = PADDR[5:2];
  assign access    = PSEL & PENABLE;
  assign mapped    = (regIdx <= ADDR_DBPRESC);
  assign PSLVERR   = access & (~mapped | (PWRITE & (regIdx == ADDR_IN)));
  assign wrEn      = access & PWRITE & ~PSLVERR;
  assign PREADY    = 1'b1;
  assign wd        = PWDATA[NUM_GPIO-1:0];
  assign unusedBus = ^{PADDR, PWDATA};

  // Debounced pins take the synchronised value only on a tick that confirms the previous tick's sample.
  assign tick   = (cnt_q == presc_q);
  assign upd    = ~dben_q | ({NUM_GPIO{tick}} & ~(sync1_q ^ sample_q));
  assign rIn_d  = (rIn_q & ~upd) | (sync1_q & upd);
  assign sample_d = tick ? sync1_q : sample_q;

  assign rise   = rIn_q & ~rPrev_q;
  assign fall   = ~rIn_q & rPrev_q;
  assign modeEv = (~type1_q & ~type0_q & rise) | (~type1_q & type0_q & fall) |
                  (type1_q & ~type0_q & rIn_q) | (type1_q & type0_q & ~rIn_q);
  assign ev     = inten_q & modeEv;
  assign wr1c   = (wrEn && regIdx == ADDR_STATUS) ? wd : '0;

  always_comb begin
    dir_d    = dir_q;
    out_d    = out_q;
    inten_d  = inten_q;
    type0_d  = type0_q;
    type1_d  = type1_q;
    dben_d   = dben_q;
    presc_d  = presc_q;
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    // New events are ORed in after the clear so a same-cycle event is never lost.
    status_d = (status_q & ~wr1c) | ev;
    if (wrEn) begin
      case (regIdx)
        ADDR_DIR:     dir_d   = wd;
        ADDR_OUT:     out_d   = wd;
        ADDR_OUTSET:  out_d   = out_q | wd;
        ADDR_OUTCLR:  out_d   = out_q & ~wd;
        ADDR_OUTTGL:  out_d   = out_q ^ wd;
        ADDR_INTEN:   inten_d = wd;
        ADDR_INTTYP0: type0_d = wd;
        ADDR_INTTYP1: type1_d = wd;
        ADDR_DBEN:    dben_d  = wd;
        ADDR_DBPRESC: begin
          presc_d = PWDATA[DB_CNT_W-1:0];
          cnt_d   = '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    PRDATA = '0;
    case (regIdx)
      ADDR_DIR:     PRDATA[NUM_GPIO-1:0] = dir_q;
      ADDR_IN:      PRDATA[NUM_GPIO-1:0] = rIn_q;
      ADDR_OUT:     PRDATA[NUM_GPIO-1:0] = out_q;
      ADDR_INTEN:   PRDATA[NUM_GPIO-1:0] = inten_q;
      ADDR_INTTYP0: PRDATA[NUM_GPIO-1:0] = type0_q;
      ADDR_INTTYP1: PRDATA[NUM_GPIO-1:0] = type1_q;
      ADDR_STATUS:  PRDATA[NUM_GPIO-1:0] = status_q;
      ADDR_DBEN:    PRDATA[NUM_GPIO-1:0] = dben_q;
      ADDR_DBPRESC: PRDATA[DB_CNT_W-1:0] = presc_q;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dir_q    <= '0;
      out_q    <= '0;
      inten_q  <= '0;
      type0_q  <= '0;
      type1_q  <= '0;
      status_q <= '0;
      dben_q   <= '0;
      presc_q  <= '0;
      cnt_q    <= '0;
      sync0_q  <= '0;
      sync1_q  <= '0;
      rIn_q    <= '0;
      rPrev_q  <= '0;
      sample_q <= '0;
    end else begin
      dir_q    <= dir_d;
      out_q    <= out_d;
      inten_q  <= inten_d;
      type0_q  <= type0_d;
      type1_q  <= type1_d;
      status_q <= status_d;
      dben_q   <= dben_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      sync0_q  <= gpio_in;
      sync1_q  <= sync0_q;
      rIn_q    <= rIn_d;
      rPrev_q  <= rIn_q;
      sample_q <= sample_d;
    end
  end

  assign gpio_out  = out_q;
  assign gpio_dir  = dir_q;
  assign interrupt = |status_q;

endmodule
